rr_req_arbiter: RTL and testbench

- Registered round-robin arbiter that shares one resource among N_REQ requesters, e.g. a shared bus port or a write port of the register file.
- Turns a request vector into a one-hot grant plus a binary grant index.
- Internally, the index search is a priority encode that starts at a rotating pointer.
- Grant is held while the owner keeps requesting; release hands over without a bubble.

---
 rtl/rr_req_arbiter_if.sv | 21 ++
 rtl/rr_req_arbiter.sv | 156 +++++++++++++++
 tb/tb_rr_req_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rr_req_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_req_arbiter_if                                         |
// | Brief    : request/grant bundle between requesters and the arbiter   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface rr_req_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [IDX_W-1:0] rr_ptr;

    modport master (output req, input gnt, gnt_idx, gnt_vld, rr_ptr);
    modport slave  (input req, output gnt, gnt_idx, gnt_vld, rr_ptr);
endinterface
`default_nettype wire

// File: rtl/rr_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_req_arbiter                                            |
// | Brief    : registered round-robin arbiter, grant held while owner    |
// |            requests; RR_ARB_HOLD_LIMIT_EN adds forced rotation.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_req_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    rr_req_arbiter_if.slave      bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0]       c_IDLE = 1'b0;
    localparam logic [0:0]       c_OWN  = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N_REQ - 1);

    if ((N_REQ < 1) || (MAX_HOLD < 2)) begin : g_param_check
        $error("rr_req_arbiter: N_REQ must be >= 1 and MAX_HOLD >= 2");
    end

    // Circular priority encode: rotate so 'start' lands on bit 0, take the
    // lowest set bit, then map back to the absolute index.
    function automatic logic [IDX_W-1:0] f_winner(
        input logic [N_REQ-1:0] mask,
        input logic [IDX_W-1:0] start
    );
        logic [N_REQ-1:0] rot;
        logic [N_REQ-1:0] tmp;
        int               pos;
        int               sum;
        rot = N_REQ'({mask, mask} >> start);
        pos = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            tmp = rot >> k;
            if (tmp[0]) pos = k;
        end
        sum = int'(start) + pos;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return IDX_W'(sum);
    endfunction

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_vld;
    logic [IDX_W-1:0] r_rr_ptr;

    logic [0:0]       w_state_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_vld_nxt;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [N_REQ-1:0] w_other;
    logic             w_own_req;
    logic [IDX_W-1:0] w_next_ptr;
    logic [IDX_W-1:0] w_win;
    logic             w_force;
    logic             w_rotate;

`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam int                HOLD_W     = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] c_HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;

    assign w_force = w_own_req && (r_hold == c_HOLD_TOP) && (|w_other);

    always_comb begin
        w_hold_nxt = '0;
        if ((r_state == c_OWN) && !w_rotate) begin
            w_hold_nxt = (r_hold == c_HOLD_TOP) ? r_hold : r_hold + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hold <= '0;
        else        r_hold <= w_hold_nxt;
    end
`else
    assign w_force = 1'b0;
`endif

    // r_gnt is the one-hot of r_gnt_idx whenever it is nonzero, so it doubles
    // as the owner mask.
    assign w_other    = bus.req & ~r_gnt;
    assign w_own_req  = |(bus.req & r_gnt);
    assign w_next_ptr = (r_gnt_idx == c_LAST) ? '0 : r_gnt_idx + 1'b1;
    assign w_rotate   = (r_state == c_OWN) && (!w_own_req || w_force);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        w_vld_nxt   = r_gnt_vld;
        w_ptr_nxt   = r_rr_ptr;
        w_win       = '0;
        case (r_state)
            c_IDLE: begin
                if (|bus.req) begin
                    w_win       = f_winner(bus.req, r_rr_ptr);
                    w_gnt_nxt   = N_REQ'(1) << w_win;
                    w_idx_nxt   = w_win;
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = c_OWN;
                end
            end
            c_OWN: begin
                if (w_rotate) begin
                    w_ptr_nxt = w_next_ptr;
                    if (|w_other) begin
                        w_win     = f_winner(w_other, w_next_ptr);
                        w_gnt_nxt = N_REQ'(1) << w_win;
                        w_idx_nxt = w_win;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_vld_nxt   = 1'b0;
                        w_state_nxt = c_IDLE;
                    end
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_vld_nxt   = 1'b0;
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_gnt_vld <= 1'b0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_idx_nxt;
            r_gnt_vld <= w_vld_nxt;
            r_rr_ptr  <= w_ptr_nxt;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_gnt_idx;
    assign bus.gnt_vld = r_gnt_vld;
    assign bus.rr_ptr  = r_rr_ptr;
endmodule
`default_nettype wire

// File: tb/tb_rr_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rr_req_arbiter                                         |
// | Brief    : directed + random bench for rr_req_arbiter with a          |
// |            queue-free owner/pointer reference model.                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_rr_req_arbiter;
    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    // Reference state: owner index (-1 = nobody), search pointer, hold cycles.
    int   m_owner;
    int   m_ptr;
    int   m_hold;

    rr_req_arbiter_if #(.N_REQ(N)) bus ();

    rr_req_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int win(input int mask, input int start);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (((mask >> j) & 1) == 1) return j;
        end
        return -1;
    endfunction

    task automatic model_edge(input int r);
        int other;
        bit own_req;
        bit force_rot;
        if (m_owner < 0) begin
            if (r != 0) begin
                m_owner = win(r, m_ptr);
                m_hold  = 0;
            end
        end else begin
            own_req   = ((r >> m_owner) & 1) == 1;
            other     = r & ~(1 << m_owner);
            force_rot = HOLD_EN && own_req && (m_hold == MAX_HOLD - 1) && (other != 0);
            if (!own_req || force_rot) begin
                m_ptr   = (m_owner + 1) % N;
                m_hold  = 0;
                m_owner = (other != 0) ? win(other, m_ptr) : -1;
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(bus.gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("gnt_vld", 32'(bus.gnt_vld), (m_owner < 0) ? 32'd0 : 32'd1);
        chk("rr_ptr", 32'(bus.rr_ptr), 32'(m_ptr));
        if (m_owner >= 0) chk("gnt_idx", 32'(bus.gnt_idx), 32'(m_owner));
    endtask

    task automatic step(input logic [N-1:0] r);
        bus.req = r;
        @(posedge clk);
        model_edge(int'(r));
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.req     = '0;

        // Reset state and idle behaviour
        do_reset();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_idx", 32'(bus.gnt_idx), 32'd0);
        chk("rst_vld", 32'(bus.gnt_vld), 32'd0);
        chk("rst_ptr", 32'(bus.rr_ptr), 32'd0);
        for (int i = 0; i < 5; i++) step(4'b0000);

        // Initial grant, hold, bubble-free handover, wrap, return to idle
        step(4'b1010);
        chk("first_win", 32'(bus.gnt), 32'h2);
        for (int i = 0; i < 3; i++) step(4'b1010);
        step(4'b1000);
        chk("handover_gnt", 32'(bus.gnt), 32'h8);
        chk("handover_ptr", 32'(bus.rr_ptr), 32'd2);
        step(4'b0001);
        chk("wrap_ptr", 32'(bus.rr_ptr), 32'd0);
        step(4'b0000);
        chk("idle_ptr", 32'(bus.rr_ptr), 32'd1);

        // Fairness: each owner drops for one cycle after two granted cycles
        do_reset();
        step(4'b1111);
        chk("rr_order0", 32'(bus.gnt_idx), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step(4'b1111);
            r = 4'b1111 & ~(4'b0001 << k);
            step(r);
            chk("rr_order", 32'(bus.gnt_idx), 32'((k + 1) % 4));
        end

        // Continuous contention between two requesters
        do_reset();
        for (int i = 0; i < 13; i++) step(4'b0011);
        chk("hold_limit_gnt", 32'(bus.gnt), HOLD_EN ? 32'h2 : 32'h1);

        // Asynchronous reset while owning
        do_reset();
        step(4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt", 32'(bus.gnt), 32'd0);
        chk("async_vld", 32'(bus.gnt_vld), 32'd0);
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100);
        chk("post_rst_gnt", 32'(bus.gnt), 32'h4);
        chk("post_rst_ptr", 32'(bus.rr_ptr), 32'd0);

        // Random traffic; owners tend to keep requesting for a while
        for (int i = 0; i < 400; i++) begin
            r = 4'($urandom_range(0, 15));
            if ((m_owner >= 0) && ($urandom_range(0, 3) != 0)) r[m_owner] = 1'b1;
            step(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
